// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 256x480 @ 60 Hz timing constants and sync-decoder state encoding
// Used by vga_sync_decoder and by the matching sync generator. No ports.
package vga_timing_pkg;
    localparam int H_VISIBLE    = 256;
    localparam int H_FRONT      = 6;
    localparam int H_SYNC       = 38;
    localparam int H_BACK       = 19;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int LOCK_FRAMES  = 2;
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one active-low sync line and flags its falling edge
// Ports: clk, reset (sync, active-low), sync_in (raw sync),
//        fall (high for one cycle after the registered sync goes 1 -> 0)
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic fall
);
    logic sync_q, sync_d;
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync_q <= sync_in;
            sync_d <= sync_q;
        end
    end
    assign fall = !sync_q && sync_d;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and lock from incoming active-low hsync/vsync
// Ports: clk, reset (sync, active-low), hsync_in/vsync_in (active-low syncs),
//        pixel_x/pixel_y/video_on (generator outputs delayed 4 cycles while locked, else 0),
//        locked (nominal timing seen for LOCK_FRAMES frames), timing_err (1-cycle error pulse).
// Define VGA_DEC_MEAS_EN to add meas_h_len / meas_v_len (measured line / frame length minus 1).
module vga_sync_decoder #(
    parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BACK      = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BACK      = vga_timing_pkg::V_BACK,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [8:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic       timing_err
`ifdef VGA_DEC_MEAS_EN
    ,
    output logic [8:0] meas_h_len,
    output logic [9:0] meas_v_len
`endif
);
    import vga_timing_pkg::*;
    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SS  = H_VISIBLE + H_FRONT;
    localparam int V_SS  = V_VISIBLE + V_FRONT;
    localparam logic [8:0] H_LAST = 9'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [8:0] H_BND  = 9'(H_TOT - H_SS);
    logic        hs_fall, vs_fall;
    logic [8:0]  h_cnt, x_src;
    logic [9:0]  v_cnt, y_src, x_sum;
    logic [10:0] y_sum;
    logic [3:0]  good_cnt;
    logic        armed, frame_bad, line_start, arm_now, line_err, frame_err, err, vis, lock_next;
    sync_state_t state;
    vga_sync_edge u_hs (.clk(clk), .reset(reset), .sync_in(hsync_in), .fall(hs_fall));
    vga_sync_edge u_vs (.clk(clk), .reset(reset), .sync_in(vsync_in), .fall(vs_fall));
    // h_cnt is 0 two cycles after the source reached H_SS, so the source column seen
    // by the output register is h_cnt + H_SS - 1; the source line turns over once
    // that sum wraps (h_cnt > H_TOT - H_SS). v_cnt is 0 on the source line V_SS.
    always_comb begin
        line_start = hs_fall || h_cnt == H_LAST;
        arm_now    = line_start && (armed || vs_fall);
        line_err   = hs_fall ? h_cnt != H_LAST : h_cnt == H_LAST;
        frame_err  = line_start && (arm_now ? v_cnt != V_LAST : v_cnt == V_LAST);
        err        = line_err || frame_err;
        x_sum      = {1'b0, h_cnt} + 10'(H_SS - 1);
        x_src      = 9'(x_sum >= 10'(H_TOT) ? x_sum - 10'(H_TOT) : x_sum);
        y_sum      = {1'b0, v_cnt} + 11'(V_SS) + {10'd0, h_cnt > H_BND};
        y_src      = 10'(y_sum >= 11'(V_TOT) ? y_sum - 11'(V_TOT) : y_sum);
        vis        = x_src < 9'(H_VISIBLE) && y_src < 10'(V_VISIBLE);
        lock_next  = state == LOCKED ? !err :
                     state == ACQUIRE && arm_now && !err && !frame_bad && good_cnt + 4'd1 == 4'(LOCK_FRAMES);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            armed      <= 1'b0;
            frame_bad  <= 1'b0;
            good_cnt   <= '0;
            state      <= SEARCH;
            locked     <= 1'b0;
            timing_err <= 1'b0;
            video_on   <= 1'b0;
            pixel_x    <= '0;
            pixel_y    <= '0;
        end else begin
            h_cnt      <= line_start ? '0 : h_cnt + 9'd1;
            v_cnt      <= !line_start ? v_cnt : (arm_now || v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            armed      <= (armed || vs_fall) && !line_start;
            timing_err <= state != SEARCH && err;
            locked     <= lock_next;
            video_on   <= lock_next && vis;
            pixel_x    <= lock_next && vis ? x_src : '0;
            pixel_y    <= lock_next && vis ? y_src : '0;
            if (state == SEARCH) begin
                if (arm_now) begin
                    state     <= ACQUIRE;
                    good_cnt  <= '0;
                    frame_bad <= 1'b0;
                end
            end else if (state == ACQUIRE) begin
                if (lock_next) begin
                    state <= LOCKED;
                end else if (arm_now) begin
                    good_cnt  <= err || frame_bad ? '0 : good_cnt + 4'd1;
                    frame_bad <= 1'b0;
                end else if (err) begin
                    good_cnt  <= '0;
                    frame_bad <= 1'b1;
                end
            end else if (err) begin
                state <= SEARCH;
            end
        end
    end
`ifdef VGA_DEC_MEAS_EN
    logic [8:0] h_since;
    logic [9:0] l_since;
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_since    <= '0;
            l_since    <= '0;
            meas_h_len <= '0;
            meas_v_len <= '0;
        end else begin
            h_since <= hs_fall ? '0 : h_since + 9'd1;
            l_since <= !line_start ? l_since : arm_now ? '0 : l_since + 10'd1;
            if (hs_fall) meas_h_len <= h_since;
            if (arm_now) meas_v_len <= l_since;
        end
    end
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of the sync decoder against a small-timing generator model
module tb_vga_sync_decoder;
    localparam int HV = 8, HF = 2, HS = 3, HB = 3, HT = 16, HSS = 10;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2, VT = 11, VSS = 7;
    localparam int FT = HT * VT;
    logic clk = 1'b0, reset = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [8:0] pixel_x;
    logic [9:0] pixel_y;
    logic video_on, locked, timing_err;
`ifdef VGA_DEC_MEAS_EN
    logic [8:0] meas_h_len;
    logic [9:0] meas_v_len;
`endif
    int passed = 0, total = 0;
    int gh = 0, gv = 0, hlen = HT, vlen = VT;
    bit gen_run = 0, hs_mask = 0;
    logic [19:0] hist [0:4];

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .locked(locked), .timing_err(timing_err)
`ifdef VGA_DEC_MEAS_EN
        , .meas_h_len(meas_h_len), .meas_v_len(meas_v_len)
`endif
    );

    always #5 clk = ~clk;

    // Source generator model; hist[k] holds its {video_on, pixel_y, pixel_x} k cycles ago.
    initial begin
        for (int i = 0; i < 5; i++) hist[i] = 20'd0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_run) begin
                gh = gh + 1;
                if (gh >= hlen) begin
                    gh = 0;
                    gv = (gv + 1 >= vlen) ? 0 : gv + 1;
                end
            end
            hsync_in = !(gen_run && gh >= HSS && gh < HSS + HS) || hs_mask;
            vsync_in = !(gen_run && gv >= VSS && gv < VSS + VS);
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = (gen_run && gh < HV && gv < VV) ? {1'b1, 10'(gv), 9'(gh)} : 20'd0;
        end
    end

    task automatic wait_pos(input int v, input int h);
        for (int i = 0; i < 8 * FT && !(gv == v && gh == h); i++) @(negedge clk);
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (locked !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic watch(input int cycles, output int errs, output int lock_seen, output int lock_at_err);
        errs = 0;
        lock_seen = 0;
        lock_at_err = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (timing_err === 1'b1) begin
                errs++;
                lock_at_err += int'(locked);
            end
            lock_seen += int'(locked === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pixel_x !== 9'd0) $display("FAIL reset_pixel_x: got %0d expected 0", pixel_x); else passed++;
        total++; if (pixel_y !== 10'd0) $display("FAIL reset_pixel_y: got %0d expected 0", pixel_y); else passed++;
        total++; if (video_on !== 1'b0) $display("FAIL reset_video_on: got %b expected 0", video_on); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else passed++;
        total++; if (timing_err !== 1'b0) $display("FAIL reset_timing_err: got %b expected 0", timing_err); else passed++;
        reset = 1'b1;
        gen_run = 1'b1;
    endtask

    task automatic test_acquire_lock();
        int n = 0, errs = 0;
        while (locked !== 1'b1 && n < 4 * FT) begin
            @(negedge clk);
            n++;
            errs += int'(timing_err === 1'b1);
        end
        total++; if (n < 2 * FT || n > 3 * FT) $display("FAIL lock_time: got %0d cycles expected %0d..%0d", n, 2 * FT, 3 * FT); else passed++;
        total++; if (errs != 0) $display("FAIL acquire_errs: got %0d expected 0", errs); else passed++;
    endtask

    task automatic test_tracking(input int frames);
        for (int i = 0; i < frames * FT; i++) begin
            @(negedge clk);
            total++;
            if ({video_on, pixel_y, pixel_x} !== hist[4] || timing_err !== 1'b0 || locked !== 1'b1)
                $display("FAIL track: got vo=%b y=%0d x=%0d err=%b lock=%b expected vo=%b y=%0d x=%0d err=0 lock=1",
                         video_on, pixel_y, pixel_x, timing_err, locked, hist[4][19], hist[4][18:9], hist[4][8:0]);
            else passed++;
        end
    endtask

    task automatic test_missing_hsync();
        int errs, seen, lae, n;
        wait_pos(3, 0);
        hs_mask = 1'b1;
        fork
            begin wait_pos(4, 0); hs_mask = 1'b0; end
            watch(3 * HT, errs, seen, lae);
        join
        total++; if (errs != 1) $display("FAIL nohs_err_pulses: got %0d expected 1", errs); else passed++;
        total++; if (lae != 0) $display("FAIL nohs_locked_at_err: got %0d expected 0", lae); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL nohs_locked_after: got %b expected 0", locked); else passed++;
        total++; if (video_on !== 1'b0 || pixel_x !== 9'd0) $display("FAIL nohs_outputs: got vo=%b x=%0d expected vo=0 x=0", video_on, pixel_x); else passed++;
        wait_locked(4 * FT, n);
        total++; if (n < FT || n > 3 * FT) $display("FAIL nohs_relock: got %0d cycles expected %0d..%0d", n, FT, 3 * FT); else passed++;
    endtask

    task automatic test_long_line();
        int errs, seen, lae, n;
        wait_pos(3, 0);
        hlen = HT + 1;
        fork
            begin wait_pos(4, 0); hlen = HT; end
            watch(3 * HT, errs, seen, lae);
        join
        total++; if (errs != 1) $display("FAIL long_err_pulses: got %0d expected 1", errs); else passed++;
        total++; if (lae != 0) $display("FAIL long_locked_at_err: got %0d expected 0", lae); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL long_locked_after: got %b expected 0", locked); else passed++;
        wait_pos(0, 0);
        hlen = HT + 1;
        watch(4 * FT, errs, seen, lae);
        total++; if (seen != 0) $display("FAIL long320_lock_cycles: got %0d expected 0", seen); else passed++;
        total++; if (errs == 0) $display("FAIL long320_err_pulses: got %0d expected >0", errs); else passed++;
        wait_pos(0, 0);
        hlen = HT;
        wait_locked(4 * FT, n);
        total++; if (n >= 4 * FT) $display("FAIL long_relock: got %0d cycles expected <%0d", n, 4 * FT); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        wait_pos(2, 5);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++; if (pixel_x !== 9'd0) $display("FAIL rst_mid_pixel_x: got %0d expected 0", pixel_x); else passed++;
        total++; if (pixel_y !== 10'd0) $display("FAIL rst_mid_pixel_y: got %0d expected 0", pixel_y); else passed++;
        total++; if (video_on !== 1'b0) $display("FAIL rst_mid_video_on: got %b expected 0", video_on); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL rst_mid_locked: got %b expected 0", locked); else passed++;
        total++; if (timing_err !== 1'b0) $display("FAIL rst_mid_timing_err: got %b expected 0", timing_err); else passed++;
        @(negedge clk);
        total++; if (locked !== 1'b0) $display("FAIL rst_mid_search_locked: got %b expected 0", locked); else passed++;
        total++; if (video_on !== 1'b0) $display("FAIL rst_mid_search_video: got %b expected 0", video_on); else passed++;
    endtask

    task automatic test_short_frame();
        int errs, seen, lae, n;
        wait_pos(VSS, HSS + 4);
        vlen = VT - 1;
        wait_pos(0, 0);
        vlen = VT;
        watch(2 * FT, errs, seen, lae);
        total++; if (errs != 1) $display("FAIL short_err_pulses: got %0d expected 1", errs); else passed++;
        total++; if (seen != 0) $display("FAIL short_lock_cycles: got %0d expected 0", seen); else passed++;
        wait_locked(2 * FT, n);
        total++; if (n < 1 || n > FT) $display("FAIL short_relock: got %0d cycles expected 1..%0d", n, FT); else passed++;
    endtask

`ifdef VGA_DEC_MEAS_EN
    task automatic test_meas();
        total++; if (meas_h_len !== 9'(HT - 1)) $display("FAIL meas_h_len: got %0d expected %0d", meas_h_len, HT - 1); else passed++;
        total++; if (meas_v_len !== 10'(VT - 1)) $display("FAIL meas_v_len: got %0d expected %0d", meas_v_len, VT - 1); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_acquire_lock();
        test_tracking(3);
        test_missing_hsync();
        test_long_line();
        test_reset_mid_frame();
        test_short_frame();
        test_tracking(1);
`ifdef VGA_DEC_MEAS_EN
        test_meas();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
